// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector.
//   state_t : FSM state encoding (IDLE, LOAD, DETECT)
//   LCNT_W  : width of the load/fill bit counters, wide enough to hold
//             any legal pattern length (up to 32) without wrapping.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DETECT = 2'd2
  } state_t;

  localparam int LCNT_W = $clog2(32 + 1);

endpackage

// File: rtl/shift_reg_n.sv
// W-bit serial-in shift register, MSB-first: new bits enter at bit 0 and
// older bits move toward bit W-1.
//   clk : clock
//   clr : synchronous clear (wins over en)
//   en  : shift enable
//   din : serial input bit
//   q   : parallel register contents
module shift_reg_n #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/seq_det_n.sv
// Programmable serial sequence detector. A W-bit pattern is shifted in
// while load is high; once at least W bits were loaded and load drops,
// the stream on din is compared against the pattern every cycle.
//   clk       : clock
//   rst       : synchronous active-high reset
//   load      : pattern-load phase when high
//   din       : pattern bit (load=1) or stream bit (load=0)
//   ovl       : 1 = overlapping matches, 0 = non-overlapping
//   dout      : one-cycle match pulse, one edge after the completing bit
//   pat_valid : high while detection is armed
//   match_cnt : saturating number of matches since the last load start
module seq_det_n
  import seq_det_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          din,
  input  logic          ovl,
  output logic          dout,
  output logic          pat_valid,
  output logic [CW-1:0] match_cnt
);

  localparam logic [LCNT_W-1:0] FULL    = LCNT_W'(W);
  localparam logic [CW-1:0]     CNT_MAX = '1;

  state_t              state, state_nxt;
  logic [LCNT_W-1:0]   lcnt, fcnt, fcnt_nxt;
  logic [W-1:0]        pattern, window, window_nxt;
  logic                load_entry, det_step, hit, hit_p1;

  function automatic logic [LCNT_W-1:0] sat_fill(input logic [LCNT_W-1:0] v);
    return (v >= FULL) ? FULL : v + LCNT_W'(1);
  endfunction

  function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CW'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load) state_nxt = LOAD;
      LOAD:    if (!load) state_nxt = (lcnt >= FULL) ? DETECT : IDLE;
      DETECT:  if (load) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // The entry edge itself captures the first pattern bit, so load held for
  // exactly W cycles yields a complete pattern.
  assign load_entry = load && (state != LOAD);
  assign det_step   = (state == DETECT) && !load;
  assign window_nxt = {window[W-2:0], din};
  assign fcnt_nxt   = sat_fill(fcnt);
  assign hit        = det_step && (window_nxt == pattern) && (fcnt_nxt == FULL);

  shift_reg_n #(.W(W)) u_pattern (
    .clk (clk),
    .clr (rst),
    .en  (load),
    .din (din),
    .q   (pattern)
  );

  shift_reg_n #(.W(W)) u_window (
    .clk (clk),
    .clr (rst || load_entry),
    .en  (det_step),
    .din (din),
    .q   (window)
  );

  // Stage p1: registered match pulse, counters and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lcnt      <= '0;
      fcnt      <= '0;
      match_cnt <= '0;
      hit_p1    <= 1'b0;
    end else begin
      state  <= state_nxt;
      hit_p1 <= hit;
      if (load_entry) begin
        lcnt      <= LCNT_W'(1);
        fcnt      <= '0;
        match_cnt <= '0;
      end else if (load) begin
        lcnt <= sat_fill(lcnt);
      end else if (det_step) begin
        // Non-overlapping mode restarts the fill so W fresh bits are needed.
        fcnt <= (hit && !ovl) ? '0 : fcnt_nxt;
        if (hit) match_cnt <= sat_cnt(match_cnt);
      end
    end
  end

  assign dout      = hit_p1;
  assign pat_valid = (state == DETECT);

endmodule
